// File: rtl/scanchain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scanchain_pkg
// Purpose  : Shared definitions for the scan-chain bridge: FSM state
//            encoding, parity-bit placement and chain-length helper.
// Config   : SCANCHAIN_PARITY_EN -- when defined, the chain carries one
//            extra even-parity bit directly above the payload.
// Revision : 1.0  initial release
// ============================================================================
package scanchain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,    // no frame open
        ST_SHIFT = 2'd1,    // frame captured, still filling
        ST_FULL  = 2'd2     // exactly one chain length shifted (or more)
    } state_e;

`ifdef SCANCHAIN_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Parity bit sits immediately above the SCAN_LENGTH payload bits.
    localparam int PARITY_POS_OFS = 0;

    function automatic int parity_pos(input int scan_length);
        return scan_length + PARITY_POS_OFS;
    endfunction

    // Total serial chain length including the optional parity bit.
    function automatic int chain_len(input int scan_length);
        return parity_pos(scan_length) + PARITY_BITS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scanchain_shreg.sv
`default_nettype none
// ============================================================================
// Module   : scanchain_shreg
// Purpose  : WIDTH-bit right-shifting register with parallel load and a
//            registered serial output taken from bit 0.
// Ports    : clk, reset      clock / async active-high reset
//            load_i          parallel load (wins over shift)
//            load_data_i     parallel load value
//            shift_i         shift one bit toward bit 0
//            serial_i        bit entering at the top
//            data_o          current register contents
//            serial_o        bit 0 as it was before the last shift
// Revision : 1.0  initial release
// ============================================================================
module scanchain_shreg
    import scanchain_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             serial_i,
    output logic [WIDTH-1:0] data_o,
    output logic             serial_o
);

    logic [WIDTH-1:0] sr_q;
    logic             ser_q;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (WIDTH == 1) begin : g_single
            assign w_shifted = serial_i;
        end else begin : g_multi
            assign w_shifted = {serial_i, sr_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            ser_q <= 1'b0;
        end else if (load_i) begin
            sr_q  <= load_data_i;       // serial output holds across capture
        end else if (shift_i) begin
            sr_q  <= w_shifted;
            ser_q <= sr_q[0];
        end
    end

    assign data_o   = sr_q;
    assign serial_o = ser_q;

endmodule
`default_nettype wire

// File: rtl/scanchain_bridge.sv
`default_nettype none
// ============================================================================
// Module   : scanchain_bridge
// Purpose  : Serial scan-chain front end for a core. Captures parallel core
//            data into a chain, shifts it out LSB first while shifting new
//            data in, and on a correctly sized frame updates the parallel
//            data driven to the core.
// Ports    : clk, reset        clock / async active-high reset
//            scan_select       capture request (highest priority)
//            latch_enable      update request
//            shift_en          one-bit shift strobe (lowest priority)
//            data_in/data_out  serial in / registered serial out
//            module_data_out   parallel capture data from the core
//            module_data_in    registered parallel data to the core
//            update_valid      1-cycle pulse on accepted update
//            frame_error       1-cycle pulse on rejected frame
// Config   : SCANCHAIN_PARITY_EN -- adds an even-parity bit over the update
//            field at chain position SCAN_LENGTH; a bad parity rejects the
//            frame.
// Revision : 1.0  initial release
// ============================================================================
module scanchain_bridge
    import scanchain_pkg::*;
#(
    parameter int SCAN_LENGTH = 96,
    parameter int OUT_WIDTH   = 70,
    parameter int IN_WIDTH    = 37
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scan_select,
    input  logic                 shift_en,
    input  logic                 latch_enable,
    input  logic                 data_in,
    output logic                 data_out,
    input  logic [OUT_WIDTH-1:0] module_data_out,
    output logic [IN_WIDTH-1:0]  module_data_in,
    output logic                 update_valid,
    output logic                 frame_error
);

    localparam int CHAIN_LEN = chain_len(SCAN_LENGTH);
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
`ifdef SCANCHAIN_PARITY_EN
    localparam int PARITY_POS = parity_pos(SCAN_LENGTH);
`endif

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovr_q, ovr_d;
    logic [IN_WIDTH-1:0]  mdi_q;
    logic                 uv_q;
    logic                 fe_q;

    logic                 w_load;
    logic                 w_shift;
    logic                 w_commit;
    logic                 w_reject;
    logic                 w_frame_ok;
    logic [CHAIN_LEN-1:0] w_cap;
    logic [CHAIN_LEN-1:0] w_chain;
    logic                 w_unused_chain;

    // Capture image: core data zero-extended to the chain, plus parity on top.
    always_comb begin
        w_cap                = '0;
        w_cap[OUT_WIDTH-1:0] = module_data_out;
`ifdef SCANCHAIN_PARITY_EN
        w_cap[PARITY_POS]    = ^module_data_out;
`endif
    end

`ifdef SCANCHAIN_PARITY_EN
    assign w_frame_ok = ~ovr_q & (w_chain[PARITY_POS] == ^w_chain[IN_WIDTH-1:0]);
`else
    assign w_frame_ok = ~ovr_q;
`endif

    // Only the low IN_WIDTH (and parity) bits are consumed in parallel.
    assign w_unused_chain = ^w_chain;

    // Next-state / control. Priority: capture > latch > shift.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_commit = 1'b0;
        w_reject = 1'b0;

        if (scan_select) begin
            w_load  = 1'b1;
            cnt_d   = '0;
            ovr_d   = 1'b0;
            state_d = ST_SHIFT;
        end else if (latch_enable) begin
            if (state_q != ST_IDLE) begin
                if ((state_q == ST_FULL) && w_frame_ok) begin
                    w_commit = 1'b1;
                end else begin
                    w_reject = 1'b1;
                end
                cnt_d   = '0;
                ovr_d   = 1'b0;
                state_d = ST_IDLE;
            end
        end else if (shift_en) begin
            case (state_q)
                ST_SHIFT: begin
                    w_shift = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // Counter stays saturated; any extra bit spoils the frame.
                    w_shift = 1'b1;
                    ovr_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            mdi_q   <= '0;
            uv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            uv_q    <= w_commit;
            fe_q    <= w_reject;
            if (w_commit) begin
                mdi_q <= w_chain[IN_WIDTH-1:0];
            end
        end
    end

    scanchain_shreg #(
        .WIDTH (CHAIN_LEN)
    ) u_shreg (
        .clk         (clk),
        .reset       (reset),
        .load_i      (w_load),
        .load_data_i (w_cap),
        .shift_i     (w_shift),
        .serial_i    (data_in),
        .data_o      (w_chain),
        .serial_o    (data_out)
    );

    assign module_data_in = mdi_q;
    assign update_valid   = uv_q;
    assign frame_error    = fe_q;

endmodule
`default_nettype wire

// File: tb/tb_scanchain_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_scanchain_bridge
// Purpose  : Self-checking bench for scanchain_bridge. Two instances share
//            the serial controls: A (8/8/8) and B (8 payload, 4-bit capture,
//            8-bit update). A frame-level reference model predicts all
//            outputs every cycle; directed frames are followed by random ones.
// Config   : SCANCHAIN_PARITY_EN -- chain grows by one parity bit.
// Revision : 1.0  initial release
// ============================================================================
module tb_scanchain_bridge;

`ifdef SCANCHAIN_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L = 8 + PB;

    logic       clk = 1'b0;
    logic       reset, scan_select, shift_en, latch_enable, data_in;
    logic [7:0] mdo_a;
    logic [3:0] mdo_b;
    logic       dout_a, dout_b, uv_a, uv_b, fe_a, fe_b;
    logic [7:0] mdi_a, mdi_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scanchain_bridge #(.SCAN_LENGTH(8), .OUT_WIDTH(8), .IN_WIDTH(8)) u_dut_a (
        .clk(clk), .reset(reset), .scan_select(scan_select), .shift_en(shift_en),
        .latch_enable(latch_enable), .data_in(data_in), .data_out(dout_a),
        .module_data_out(mdo_a), .module_data_in(mdi_a),
        .update_valid(uv_a), .frame_error(fe_a)
    );

    scanchain_bridge #(.SCAN_LENGTH(8), .OUT_WIDTH(4), .IN_WIDTH(8)) u_dut_b (
        .clk(clk), .reset(reset), .scan_select(scan_select), .shift_en(shift_en),
        .latch_enable(latch_enable), .data_in(data_in), .data_out(dout_b),
        .module_data_out(mdo_b), .module_data_in(mdi_b),
        .update_valid(uv_b), .frame_error(fe_b)
    );

    // ---------------- reference model (frame level) ----------------
    logic [L-1:0] m_sr   [2];
    int           m_n    [2];   // shifts since capture, -1 when no frame open
    logic         m_dout [2];
    logic [7:0]   m_mdi  [2];
    logic         m_uv   [2];
    logic         m_fe   [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [L-1:0] capture(input int k);
        logic [L-1:0] v;
        v = '0;
        if (k == 0) v[7:0] = mdo_a;
        else        v[3:0] = mdo_b;
        if (PB == 1) v[L-1] = ^v[7:0];
        return v;
    endfunction

    function automatic logic parity_ok(input logic [L-1:0] sr);
        return (PB == 0) || (sr[L-1] == ^sr[7:0]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sr[k] = '0; m_n[k] = -1; m_dout[k] = 1'b0;
            m_mdi[k] = '0; m_uv[k] = 1'b0; m_fe[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            m_uv[k] = 1'b0;
            m_fe[k] = 1'b0;
            if (reset) begin
                m_sr[k] = '0; m_n[k] = -1; m_dout[k] = 1'b0; m_mdi[k] = '0;
            end else if (scan_select) begin
                m_sr[k] = capture(k);
                m_n[k]  = 0;
            end else if (latch_enable) begin
                if (m_n[k] >= 0) begin
                    // Accepted only when exactly one chain length was shifted.
                    if (m_n[k] == L && parity_ok(m_sr[k])) begin
                        m_mdi[k] = m_sr[k][7:0];
                        m_uv[k]  = 1'b1;
                    end else begin
                        m_fe[k]  = 1'b1;
                    end
                    m_n[k] = -1;
                end
            end else if (shift_en && m_n[k] >= 0) begin
                m_dout[k] = m_sr[k][0];
                m_sr[k]   = (m_sr[k] >> 1) | (L'(data_in) << (L - 1));
                m_n[k]++;
            end
        end
    endtask

    task automatic cmp_all();
        chk("a_dout", dout_a, m_dout[0]);
        chk("a_mdi",  mdi_a,  m_mdi[0]);
        chk("a_uv",   uv_a,   m_uv[0]);
        chk("a_fe",   fe_a,   m_fe[0]);
        chk("b_dout", dout_b, m_dout[1]);
        chk("b_mdi",  mdi_b,  m_mdi[1]);
        chk("b_uv",   uv_b,   m_uv[1]);
        chk("b_fe",   fe_b,   m_fe[1]);
    endtask

    task automatic cyc(input logic s, input logic l, input logic sh, input logic d);
        scan_select  = s;
        latch_enable = l;
        shift_en     = sh;
        data_in      = d;
        @(posedge clk);
        model_edge();
        #1;
        cmp_all();
    endtask

    task automatic shift_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, v[i]);
    endtask

    // Frame payload with correct parity appended when enabled.
    function automatic logic [15:0] framed(input logic [7:0] p);
        logic [15:0] v;
        v = {8'h00, p};
        if (PB == 1) v[8] = ^p;
        return v;
    endfunction

    initial begin
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        int         n;

        reset = 1'b1; scan_select = 1'b0; shift_en = 1'b0;
        latch_enable = 1'b0; data_in = 1'b0; mdo_a = '0; mdo_b = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        cmp_all();
        reset = 1'b0;

        // Capture A5 and read it back LSB first; B sees 4'h5 zero-extended.
        mdo_a = 8'hA5; mdo_b = 4'h5;
        exp_a = 8'hA5; exp_b = 8'h05;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 1'($urandom_range(1, 0)));
            chk("a5_seq", dout_a, exp_a[i]);
            chk("b_zext_seq", dout_b, exp_b[i]);
        end
        cyc(0, 1, 0, 0);

        // Full frame 3C updates the core with a single-cycle pulse.
        cyc(1, 0, 0, 0);
        shift_bits(framed(8'h3C), L);
        cyc(0, 1, 0, 0);
        chk("upd_mdi", mdi_a, 8'h3C);
        chk("upd_pulse", uv_a, 1'b1);
        cyc(0, 0, 0, 0);
        chk("upd_pulse_end", uv_a, 1'b0);
        chk("upd_hold", mdi_a, 8'h3C);

        // Short frame is rejected.
        cyc(1, 0, 0, 0);
        shift_bits(16'h00FF, 5);
        cyc(0, 1, 0, 0);
        chk("short_fe", fe_a, 1'b1);
        chk("short_mdi", mdi_a, 8'h3C);

        // Overrun frame is rejected.
        cyc(1, 0, 0, 0);
        shift_bits({7'h00, framed(8'h99)} << 1, L + 1);
        cyc(0, 1, 0, 0);
        chk("ovr_fe", fe_a, 1'b1);
        chk("ovr_uv", uv_a, 1'b0);
        chk("ovr_mdi", mdi_a, 8'h3C);

        // Asynchronous reset mid-frame, then a normal frame.
        mdo_a = 8'hFF; mdo_b = 4'hF;
        cyc(1, 0, 0, 0);
        shift_bits(16'h0000, 4);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        cmp_all();
        chk("arst_mdi", mdi_a, 8'h00);
        chk("arst_dout", dout_a, 1'b0);
        @(posedge clk);
        model_edge();
        #1;
        cmp_all();
        reset = 1'b0;
        cyc(1, 0, 0, 0);
        shift_bits(framed(8'h5A), L);
        cyc(0, 1, 0, 0);
        chk("post_rst_mdi", mdi_a, 8'h5A);
        chk("post_rst_uv", uv_a, 1'b1);

`ifdef SCANCHAIN_PARITY_EN
        // Bad parity rejected, good parity accepted.
        cyc(1, 0, 0, 0);
        shift_bits(16'h013C, L);
        cyc(0, 1, 0, 0);
        chk("par_bad_fe", fe_a, 1'b1);
        chk("par_bad_mdi", mdi_a, 8'h5A);
        cyc(1, 0, 0, 0);
        shift_bits(16'h003C, L);
        cyc(0, 1, 0, 0);
        chk("par_ok_uv", uv_a, 1'b1);
        chk("par_ok_mdi", mdi_a, 8'h3C);
`endif

        // Capture and latch together on a full frame: capture wins.
        mdo_a = 8'h6E; mdo_b = 4'h9;
        cyc(1, 0, 0, 0);
        shift_bits(framed(8'hC3), L);
        cyc(1, 1, 0, 0);
        chk("cap_win_uv", uv_a, 1'b0);
        chk("cap_win_fe", fe_a, 1'b0);
        shift_bits(16'h0000, 8);
        cyc(0, 1, 0, 0);

        // Random frames with lengths clustered around the chain length.
        for (int f = 0; f < 60; f++) begin
            mdo_a = 8'($urandom);
            mdo_b = 4'($urandom);
            cyc(1, 0, 0, 0);
            case ($urandom_range(4, 0))
                0:       n = L - 1;
                1, 2:    n = L;
                3:       n = L + 1;
                default: n = int'($urandom_range(L + 2, 0));
            endcase
            while (n > 0) begin
                if ($urandom_range(7, 0) == 0) begin
                    cyc(0, 0, 0, 1'($urandom_range(1, 0)));   // idle gap
                end else begin
                    cyc(0, 0, 1, 1'($urandom_range(1, 0)));
                    n--;
                end
            end
            cyc($urandom_range(9, 0) == 0, 1, 1'($urandom_range(1, 0)), 0);
            // Stray strobes while no frame is open.
            cyc(0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            cyc(0, 0, 1, 1'($urandom_range(1, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
